// File: rtl/bch_seq_pkg.sv
// Shared types, stage indices and stage-order helpers for the BCH pipeline sequencer.
package bch_seq_pkg;

   localparam int unsigned SEQ_NUM_STAGES  = 4;
   localparam int unsigned SEQ_FRAME_CNT_W = 8;
   localparam int unsigned SEQ_TMO_W       = 16;
   localparam int unsigned STG_IDX_W       = 3;

   localparam logic [STG_IDX_W-1:0] STG_ENC    = 3'd0;
   localparam logic [STG_IDX_W-1:0] STG_NOISE  = 3'd1;
   localparam logic [STG_IDX_W-1:0] STG_ERRGEN = 3'd2;
   localparam logic [STG_IDX_W-1:0] STG_DEC    = 3'd3;
   localparam logic [STG_IDX_W-1:0] STG_NONE   = 3'd4;

   typedef enum logic [2:0] {
      SEQ_IDLE   = 3'd0,
      SEQ_ENCODE = 3'd1,
      SEQ_NOISE  = 3'd2,
      SEQ_ERRGEN = 3'd3,
      SEQ_DECODE = 3'd4,
      SEQ_DONE   = 3'd5,
      SEQ_ERROR  = 3'd6
   } seq_state_t;

   // Next enabled stage strictly above cur, or STG_NONE.
   function automatic logic [STG_IDX_W-1:0] next_stage(input logic [SEQ_NUM_STAGES-1:0] en_mask,
                                                       input logic [STG_IDX_W-1:0]      cur);
      logic [STG_IDX_W-1:0] r;
      r = STG_NONE;
      for (int i = int'(SEQ_NUM_STAGES) - 1; i >= 0; i--) begin
         if (en_mask[i] && (i > int'(cur))) r = 3'(i);
      end
      return r;
   endfunction

   function automatic logic [STG_IDX_W-1:0] lowest_stage(input logic [SEQ_NUM_STAGES-1:0] en_mask);
      logic [STG_IDX_W-1:0] r;
      r = STG_NONE;
      for (int i = int'(SEQ_NUM_STAGES) - 1; i >= 0; i--) begin
         if (en_mask[i]) r = 3'(i);
      end
      return r;
   endfunction

   function automatic logic is_stage_state(input seq_state_t s);
      return (s == SEQ_ENCODE) || (s == SEQ_NOISE) || (s == SEQ_ERRGEN) || (s == SEQ_DECODE);
   endfunction

endpackage

// File: rtl/bch_stage_watchdog.sv
// Per-stage cycle counter; expired_o is high during the stage cycle whose count equals limit-1.
module bch_stage_watchdog #(
   parameter int unsigned TMO_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear_i,
   input  logic             enable_i,
   input  logic [TMO_W-1:0] limit_i,
   output logic             expired_o
);

   logic [TMO_W-1:0] cnt_q, cnt_d;
   logic             expired_q, expired_d;

   // Expiry is precomputed from the next count so the flag itself is a register.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + TMO_W'(1);
      end
      expired_d = (limit_i != '0) && (cnt_d == (limit_i - TMO_W'(1)));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         expired_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         expired_q <= expired_d;
      end
   end

   assign expired_o = expired_q;

endmodule

// File: rtl/bch_pipeline_sequencer.sv
// Sequences encode/noise/errgen/decode stages over one or more frames with
// per-stage timeout, abort and busy/done/error status.
module bch_pipeline_sequencer
   import bch_seq_pkg::*;
#(
   parameter int unsigned NUM_STAGES  = 4,
   parameter int unsigned FRAME_CNT_W = 8,
   parameter int unsigned TMO_W       = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cfg_start,
   input  logic                   cfg_abort,
   input  logic [NUM_STAGES-1:0]  cfg_stage_en,
   input  logic [FRAME_CNT_W-1:0] cfg_num_frames,
   input  logic [TMO_W-1:0]       cfg_timeout,
   output logic [NUM_STAGES-1:0]  stage_start,
   input  logic [NUM_STAGES-1:0]  stage_done,
   output logic                   busy,
   output logic                   run_done,
   output logic                   err_timeout,
   output logic [1:0]             err_stage,
   output logic [2:0]             state_o,
   output logic [FRAME_CNT_W-1:0] frames_done,
   output logic [31:0]            busy_cycles
);

   localparam int unsigned FW1 = FRAME_CNT_W + 1;

   seq_state_t             state_q, state_d;
   logic [NUM_STAGES-1:0]  en_q, en_d;
   logic [FRAME_CNT_W-1:0] nf_q, nf_d;
   logic [TMO_W-1:0]       tmo_q, tmo_d;
   logic [NUM_STAGES-1:0]  start_q, start_d;
   logic                   busy_q, busy_d;
   logic                   run_done_q, run_done_d;
   logic                   err_to_q, err_to_d;
   logic [1:0]             err_stage_q, err_stage_d;
   logic [FRAME_CNT_W-1:0] frames_q, frames_d;
   logic [31:0]            busy_cyc_q, busy_cyc_d;

   logic                   in_stage;
   logic                   accept;
   logic                   wd_clear;
   logic                   wd_expired;
   logic                   do_enter;
   logic [STG_IDX_W-1:0]   tgt;
   logic [STG_IDX_W-1:0]   nxt;
   logic [STG_IDX_W-1:0]   st_raw;
   logic [1:0]             cur_idx;

   bch_stage_watchdog #(
      .TMO_W (TMO_W)
   ) u_watchdog (
      .clk       (clk),
      .rst       (rst),
      .clear_i   (wd_clear),
      .enable_i  (in_stage),
      .limit_i   (tmo_d),
      .expired_o (wd_expired)
   );

   // Next-state, config latch and status update.
   always_comb begin
      state_d     = state_q;
      en_d        = en_q;
      nf_d        = nf_q;
      tmo_d       = tmo_q;
      start_d     = '0;
      run_done_d  = run_done_q;
      err_to_d    = err_to_q;
      err_stage_d = err_stage_q;
      frames_d    = frames_q;
      busy_cyc_d  = busy_cyc_q;
      wd_clear    = 1'b0;
      do_enter    = 1'b0;
      tgt         = STG_NONE;
      nxt         = STG_NONE;

      in_stage = is_stage_state(state_q);
      st_raw   = 3'(state_q);
      cur_idx  = 2'(st_raw - 3'd1);
      accept   = cfg_start && ((state_q == SEQ_IDLE) || (state_q == SEQ_DONE) ||
                               (state_q == SEQ_ERROR));

      if (in_stage && !cfg_abort && (busy_cyc_q != '1)) begin
         busy_cyc_d = busy_cyc_q + 32'd1;
      end

      if (cfg_abort) begin
         state_d = SEQ_IDLE;
      end else if (accept) begin
         en_d        = cfg_stage_en;
         nf_d        = (cfg_num_frames == '0) ? FRAME_CNT_W'(1) : cfg_num_frames;
         tmo_d       = cfg_timeout;
         run_done_d  = 1'b0;
         err_to_d    = 1'b0;
         err_stage_d = 2'd0;
         frames_d    = '0;
         busy_cyc_d  = '0;
         tgt         = lowest_stage(cfg_stage_en);
         if (tgt == STG_NONE) begin
            state_d    = SEQ_DONE;
            run_done_d = 1'b1;
         end else begin
            do_enter = 1'b1;
         end
      end else if (in_stage) begin
         if (stage_done[cur_idx]) begin
            nxt = next_stage(en_q, {1'b0, cur_idx});
            if (nxt != STG_NONE) begin
               tgt      = nxt;
               do_enter = 1'b1;
            end else begin
               frames_d = frames_q + FRAME_CNT_W'(1);
               if (({1'b0, frames_q} + FW1'(1)) < {1'b0, nf_q}) begin
                  tgt      = lowest_stage(en_q);
                  do_enter = 1'b1;
               end else begin
                  state_d    = SEQ_DONE;
                  run_done_d = 1'b1;
               end
            end
         end else if (wd_expired) begin
            state_d     = SEQ_ERROR;
            err_to_d    = 1'b1;
            err_stage_d = cur_idx;
         end
      end

      // Stage entry: state, one-cycle start pulse and watchdog restart.
      if (do_enter) begin
         state_d             = seq_state_t'(tgt + 3'd1);
         start_d[tgt[1:0]]   = 1'b1;
         wd_clear            = 1'b1;
      end

      busy_d = is_stage_state(state_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= SEQ_IDLE;
         en_q        <= '0;
         nf_q        <= '0;
         tmo_q       <= '0;
         start_q     <= '0;
         busy_q      <= 1'b0;
         run_done_q  <= 1'b0;
         err_to_q    <= 1'b0;
         err_stage_q <= 2'd0;
         frames_q    <= '0;
         busy_cyc_q  <= '0;
      end else begin
         state_q     <= state_d;
         en_q        <= en_d;
         nf_q        <= nf_d;
         tmo_q       <= tmo_d;
         start_q     <= start_d;
         busy_q      <= busy_d;
         run_done_q  <= run_done_d;
         err_to_q    <= err_to_d;
         err_stage_q <= err_stage_d;
         frames_q    <= frames_d;
         busy_cyc_q  <= busy_cyc_d;
      end
   end

   assign stage_start = start_q;
   assign busy        = busy_q;
   assign run_done    = run_done_q;
   assign err_timeout = err_to_q;
   assign err_stage   = err_stage_q;
   assign state_o     = 3'(state_q);
   assign frames_done = frames_q;
   assign busy_cycles = busy_cyc_q;

endmodule
